// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package ifetch_pkg;

  typedef enum logic [1:0] {
    StFetch,
    StDrain,
    StHold,
    StFault
  } ifetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam int unsigned PC_STEP   = 4;

endpackage

// File: rtl/ifetch_hold_buf.sv
// Single-entry {PC+4, instruction} buffer that parks a fetched word while the
// pipeline is stalled.
module ifetch_hold_buf #(
  parameter int unsigned NBits = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             clear_i,
  input  logic [NBits-1:0] pc4_i,
  input  logic [NBits-1:0] instr_i,
  output logic             valid_o,
  output logic [NBits-1:0] pc4_o,
  output logic [NBits-1:0] instr_o
);

  logic             valid_q;
  logic [NBits-1:0] pc4_q;
  logic [NBits-1:0] instr_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      pc4_q   <= '0;
      instr_q <= '0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
      pc4_q   <= '0;
      instr_q <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      pc4_q   <= pc4_i;
      instr_q <= instr_i;
    end
  end

  assign valid_o = valid_q;
  assign pc4_o   = pc4_q;
  assign instr_o = instr_q;

endmodule

// File: rtl/instruction_fetch_stage.sv
// Instruction-fetch stage: owns the PC, talks to a variable-latency imem and
// feeds IF/ID. Optional misaligned-redirect fault is enabled by IFETCH_MISALIGN_EN.
module instruction_fetch_stage
  import ifetch_pkg::*;
#(
  parameter int unsigned      NBits    = 32,
  parameter logic [NBits-1:0] RESET_PC = 32'h0040_0000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall_i,
  input  logic             redirect_i,
  input  logic [NBits-1:0] redirect_pc_i,
  output logic             imem_req_o,
  output logic [NBits-1:0] imem_addr_o,
  input  logic             imem_ready_i,
  input  logic [NBits-1:0] imem_rdata_i,
  output logic [NBits-1:0] out_PC_4,
  output logic [NBits-1:0] out_Instruction,
  output logic             out_valid
`ifdef IFETCH_MISALIGN_EN
  ,
  output logic             misalign_o
`endif
);

  localparam logic [NBits-1:0] Nop  = NBits'(NOP_INSTR);
  localparam logic [NBits-1:0] Step = NBits'(PC_STEP);

  ifetch_state_e    state_q, state_d;
  logic [NBits-1:0] pc_q, pc_d;
  logic [NBits-1:0] target_q, target_d;
  logic [NBits-1:0] out_pc4_q, out_pc4_d;
  logic [NBits-1:0] out_instr_q, out_instr_d;
  logic             out_valid_q, out_valid_d;

  logic             buf_load, buf_clear, buf_valid;
  logic [NBits-1:0] buf_pc4, buf_instr;
  logic [NBits-1:0] pc_inc;
  logic [NBits-1:0] tgt;
  logic             tgt_bad;
  logic             bubble;

`ifdef IFETCH_MISALIGN_EN
  assign tgt        = redirect_pc_i;
  assign tgt_bad    = |redirect_pc_i[1:0];
  assign misalign_o = (state_q == StFault);
`else
  assign tgt        = redirect_pc_i & ~NBits'(3);
  assign tgt_bad    = 1'b0;
`endif

  assign pc_inc = pc_q + Step;

  ifetch_hold_buf #(
    .NBits (NBits)
  ) u_hold_buf (
    .clk     (clk),
    .reset   (reset),
    .load_i  (buf_load),
    .clear_i (buf_clear),
    .pc4_i   (pc_inc),
    .instr_i (imem_rdata_i),
    .valid_o (buf_valid),
    .pc4_o   (buf_pc4),
    .instr_o (buf_instr)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    target_d    = target_q;
    out_pc4_d   = out_pc4_q;
    out_instr_d = out_instr_q;
    out_valid_d = out_valid_q;
    buf_load    = 1'b0;
    buf_clear   = 1'b0;
    bubble      = 1'b0;
    unique case (state_q)
      StFetch: begin
        if (redirect_i) begin
          bubble = 1'b1;
          if (tgt_bad) begin
            state_d = StFault;
          end else if (imem_ready_i) begin
            pc_d = tgt;
          end else begin
            // Request in flight cannot be withdrawn; remember where to go next.
            target_d = tgt;
            state_d  = StDrain;
          end
        end else if (stall_i) begin
          if (imem_ready_i) begin
            buf_load = 1'b1;
            pc_d     = pc_inc;
            state_d  = StHold;
          end
        end else if (imem_ready_i) begin
          out_pc4_d   = pc_inc;
          out_instr_d = imem_rdata_i;
          out_valid_d = 1'b1;
          pc_d        = pc_inc;
        end else begin
          bubble = 1'b1;
        end
      end
      StDrain: begin
        if (redirect_i) begin
          bubble = 1'b1;
          if (tgt_bad) begin
            state_d = StFault;
          end else if (imem_ready_i) begin
            pc_d    = tgt;
            state_d = StFetch;
          end else begin
            target_d = tgt;
          end
        end else begin
          bubble = !stall_i;
          if (imem_ready_i) begin
            pc_d    = target_q;
            state_d = StFetch;
          end
        end
      end
      StHold: begin
        if (redirect_i) begin
          bubble    = 1'b1;
          buf_clear = 1'b1;
          if (tgt_bad) begin
            state_d = StFault;
          end else begin
            pc_d    = tgt;
            state_d = StFetch;
          end
        end else if (!stall_i) begin
          out_pc4_d   = buf_pc4;
          out_instr_d = buf_instr;
          out_valid_d = buf_valid;
          buf_clear   = 1'b1;
          state_d     = StFetch;
        end
      end
      StFault: begin
        bubble = 1'b1;
      end
      default: begin
        state_d = StFetch;
      end
    endcase
    if (bubble) begin
      out_instr_d = Nop;
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StFetch;
      pc_q        <= RESET_PC;
      target_q    <= RESET_PC;
      out_pc4_q   <= '0;
      out_instr_q <= Nop;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      target_q    <= target_d;
      out_pc4_q   <= out_pc4_d;
      out_instr_q <= out_instr_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Gated by reset so no request is seen until reset is released.
  assign imem_req_o      = reset && ((state_q == StFetch) || (state_q == StDrain));
  assign imem_addr_o     = pc_q;
  assign out_PC_4        = out_pc4_q;
  assign out_Instruction = out_instr_q;
  assign out_valid       = out_valid_q;

endmodule

// File: doc/instruction_fetch_stage.md
# instruction_fetch_stage

Instruction-fetch stage of the five-stage pipeline. It owns the program counter, issues word requests to a variable-latency instruction memory, and produces the PC+4 / instruction pair that the IF/ID pipeline register captures on the falling clock edge. It also absorbs hazard-unit stalls and branch/jump redirects from downstream stages.

## Interface
- NBits, 32, datapath and address width
- RESET_PC, 32'h0040_0000, PC value loaded on reset
- clk  in  1  all state updates on the rising edge
- reset  in  1  reset reset, asynchronous, active-low
- stall_i  in  1  hazard-unit stall; hold the outputs
- redirect_i  in  1  branch/jump taken; flush and refetch
- redirect_pc_i  in  NBits  redirect target
- imem_req_o  out  1  fetch request
- imem_addr_o  out  NBits  word address, equal to the PC register
- imem_ready_i  in  1  memory returns data this cycle
- imem_rdata_i  in  NBits  fetched word, valid when imem_ready_i=1
- out_PC_4  out  NBits  fetched PC + 4
- out_Instruction  out  NBits  fetched instruction; 0 (NOP) when bubble
- out_valid  out  1  out_* hold a real instruction

## Operation
- States:
  - FETCH: a request is outstanding on PC.
  - DRAIN: a request is outstanding on a stale PC; the returned word is discarded.
  - HOLD: a word is buffered because of a stall; no request is issued.
- imem_req_o=1 in FETCH and DRAIN. imem_addr_o is stable until imem_ready_i=1, and the request is never withdrawn mid-flight.
- FETCH with ready=1, no stall, no redirect:
  - out_* <= {PC+4, rdata}, out_valid <= 1.
  - PC <= PC+4; stay in FETCH.
- FETCH with ready=1 and stall_i=1:
  - The word goes to the hold buffer; PC <= PC+4.
  - Go to HOLD; out_* are held.
- FETCH with ready=0 and stall_i=0: out_Instruction <= 0, out_valid <= 0 (bubble).
- Any state with stall_i=1 and no redirect: out_* are held unchanged.
- HOLD with stall_i=0: the buffer moves to out_*, out_valid <= 1; go to FETCH.
- Redirect has priority over stall and ready. Outputs become a bubble (out_valid <= 0, out_Instruction <= 0).
  - FETCH with ready=1, or HOLD: PC <= redirect_pc_i; go to FETCH.
  - FETCH with ready=0: latch the target; go to DRAIN.
  - DRAIN: update the latched target.
- DRAIN with ready=1: discard the word; PC <= latched target; go to FETCH.
- Arithmetic: PC+4 wraps modulo 2^NBits (0xFFFF_FFFC + 4 = 0).
- Reset (asynchronous, any state including mid-request):
  - PC=RESET_PC, state FETCH.
  - out_PC_4=0, out_Instruction=0, out_valid=0.
  - Hold buffer cleared.
  - imem_req_o rises in the first cycle after reset deasserts.

## Timing
- Zero-wait memory (ready tied 1): one instruction per cycle. out_* update at the rising edge on which ready=1, giving IF/ID half a cycle of setup.
- N wait states: N bubbles per instruction.
- Redirect penalty with ready=1: the target is requested in the cycle after the redirect edge.
- Redirect penalty in DRAIN: the remaining stale-request latency, plus one cycle.
- Stall release from HOLD: the buffered instruction appears at the first edge with stall_i=0. The next request starts in the following cycle.

## Configuration
- IFETCH_MISALIGN_EN defined:
  - Adds output misalign_o (1 bit).
  - Redirect to a target with [1:0]≠0 enters a FAULT state and sets misalign_o=1.
  - In FAULT, imem_req_o=0 and out_* are bubbles until reset.
  - misalign_o resets to 0.
- IFETCH_MISALIGN_EN undefined: redirect_pc_i[1:0] are forced to 00 and no fault is possible.

## Structure
- Package ifetch_pkg:
  - state enum (FETCH, DRAIN, HOLD, FAULT).
  - NOP_INSTR=0.
  - PC_STEP=4.
- One sub-module, ifetch_hold_buf: a single-entry {PC+4, instruction} buffer with load, clear and valid.

## Test plan
- Reset, then ready=1 with rdata=0x2008_0005: imem_addr_o=0x0040_0000 first; the next edge gives out_PC_4=0x0040_0004, out_Instruction=0x2008_0005, out_valid=1.
- ready low for 2 cycles per fetch: 2 bubbles (out_valid=0, out_Instruction=0) between instructions, and imem_addr_o stays stable while waiting.
- stall_i=1 for 3 cycles while a fetch completes: out_* are unchanged, state is HOLD; on release the buffered word appears with out_valid=1.
- redirect_i to 0x0040_0100 while ready=0: the DRAIN word is discarded, the next request is at 0x0040_0100, and out_PC_4=0x0040_0104.
- redirect_i and stall_i in the same cycle: a bubble is output and the fetch resumes at the target.
- Async reset asserted mid-request: outputs are 0 immediately, PC=0x0040_0000 afterwards; with IFETCH_MISALIGN_EN, a redirect to 0x0040_0102 sets misalign_o=1 and imem_req_o=0.
